// File: rtl/march_bist_ctrl_pkg.sv
// Shared definitions for the March C- memory-BIST controller.
// Contents:
//   state_e    - controller states (element states M0..M5 encode the element index)
//   phase_e    - per-address op phase (PH_RD / PH_WR)
//   elem_t     - per-element descriptor: direction, first-op data polarity, op count
//   elem_info  - March C- element table
//   op_inv     - data polarity of a given op inside an element
package march_bist_ctrl_pkg;

  // M0..M5 are 0..5 so the state code doubles as the element index
  typedef enum logic [2:0] {
    ST_M0   = 3'd0,
    ST_M1   = 3'd1,
    ST_M2   = 3'd2,
    ST_M3   = 3'd3,
    ST_M4   = 3'd4,
    ST_M5   = 3'd5,
    ST_IDLE = 3'd6,
    ST_DONE = 3'd7
  } state_e;

  typedef enum logic {
    PH_RD = 1'b0,
    PH_WR = 1'b1
  } phase_e;

  // down: address sweep direction; first_inv: first op uses ~BG;
  // two_op: read-then-write element; first_wr: first op is a write
  typedef struct packed {
    logic down;
    logic first_inv;
    logic two_op;
    logic first_wr;
  } elem_t;

  // March C-: up(w0) up(r0,w1) up(r1,w0) down(r0,w1) down(r1,w0) up(r0)
  function automatic elem_t elem_info(input state_e st);
    elem_t e;
    e = '0;
    case (st)
      ST_M0:   e = '{down: 1'b0, first_inv: 1'b0, two_op: 1'b0, first_wr: 1'b1};
      ST_M1:   e = '{down: 1'b0, first_inv: 1'b0, two_op: 1'b1, first_wr: 1'b0};
      ST_M2:   e = '{down: 1'b0, first_inv: 1'b1, two_op: 1'b1, first_wr: 1'b0};
      ST_M3:   e = '{down: 1'b1, first_inv: 1'b0, two_op: 1'b1, first_wr: 1'b0};
      ST_M4:   e = '{down: 1'b1, first_inv: 1'b1, two_op: 1'b1, first_wr: 1'b0};
      ST_M5:   e = '{down: 1'b0, first_inv: 1'b0, two_op: 1'b0, first_wr: 1'b0};
      default: e = '0;
    endcase
    return e;
  endfunction

  // Trailing write of a two-op element inverts the polarity of its read
  function automatic logic op_inv(input elem_t e, input phase_e ph);
    return (e.two_op && (ph == PH_WR)) ? ~e.first_inv : e.first_inv;
  endfunction

endpackage

// File: rtl/march_bist_ctrl_addr_gen.sv
// Address sweep counter for the March BIST controller.
// Ports:
//   clk, rst_n   - clock, async active-low reset
//   load_i       - load the first address of an element (0 or all-ones)
//   load_down_i  - direction of the element being loaded
//   step_i       - advance one address in direction down_i
//   down_i       - direction of the element currently executing
//   addr_o       - registered address (drives the RAM directly)
//   tc_c_o       - combinational terminal-count flag for the current direction
module march_bist_ctrl_addr_gen #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              load_down_i,
  input  logic              step_i,
  input  logic              down_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              tc_c_o
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

  logic [ADDR_W-1:0] addr_q, addr_d;

  // Load takes priority over step
  always_comb begin
    addr_d = addr_q;
    if (load_i) begin
      addr_d = load_down_i ? ADDR_MAX : '0;
    end else if (step_i) begin
      addr_d = down_i ? (addr_q - ADDR_W'(1)) : (addr_q + ADDR_W'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr_o = addr_q;
  assign tc_c_o = down_i ? (addr_q == '0) : (addr_q == ADDR_MAX);

endmodule

// File: rtl/march_bist_ctrl.sv
// March C- memory-BIST initiator for a single-port RAM (async read, sync write).
// Runs the six March C- elements over the whole array, one RAM op per cycle,
// and raises a sticky fail flag on any read-back mismatch.
// Ports:
//   clk, rst_n  - clock, async active-low reset
//   start       - begin a test (accepted only in IDLE or DONE)
//   mem_addr    - RAM address
//   mem_wdata   - RAM write data
//   mem_wr      - RAM write enable
//   mem_rdata   - RAM read data (combinational from mem_addr)
//   busy        - a March element is executing
//   done        - test finished, held until the next accepted start
//   fail        - sticky mismatch flag, cleared on accepted start
// Optional macro BIST_DIAG_EN adds first-mismatch capture (fail_addr, fail_data,
// fail_elem) and a saturating mismatch counter (err_cnt).
module march_bist_ctrl #(
  parameter int unsigned        ADDR_W = 8,
  parameter int unsigned        DATA_W = 8,
  parameter logic [DATA_W-1:0]  BG     = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              fail
`ifdef BIST_DIAG_EN
  ,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic [2:0]        fail_elem,
  output logic [7:0]        err_cnt
`endif
);

  import march_bist_ctrl_pkg::*;

  state_e            state_q, state_d;
  phase_e            phase_q, phase_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              fail_q, fail_d;
  logic              mem_wr_q, mem_wr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic              ag_load_c, ag_load_down_c, ag_step_c, tc_c;
  logic              start_ok_c, mismatch_c;
  elem_t             cur_c;
  logic [DATA_W-1:0] exp_c;

  march_bist_ctrl_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (ag_load_c),
    .load_down_i (ag_load_down_c),
    .step_i      (ag_step_c),
    .down_i      (cur_c.down),
    .addr_o      (mem_addr),
    .tc_c_o      (tc_c)
  );

  // Current element descriptor and the value its reads expect
  assign cur_c      = elem_info(state_q);
  assign exp_c      = cur_c.first_inv ? ~BG : BG;
  assign start_ok_c = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign mismatch_c = busy_q && (phase_q == PH_RD) && (mem_rdata != exp_c);

  // Next-state: element sequencing, phase toggle, address control, bus for the next op
  always_comb begin
    elem_t nxt;
    elem_t ne;
    state_d        = state_q;
    phase_d        = phase_q;
    busy_d         = busy_q;
    done_d         = done_q;
    fail_d         = fail_q;
    mem_wr_d       = 1'b0;
    mem_wdata_d    = mem_wdata_q;
    ag_load_c      = 1'b0;
    ag_load_down_c = 1'b0;
    ag_step_c      = 1'b0;
    nxt            = elem_info(state_e'(3'(state_q) + 3'd1));

    if (start_ok_c) begin
      state_d   = ST_M0;
      phase_d   = PH_WR;
      busy_d    = 1'b1;
      done_d    = 1'b0;
      fail_d    = 1'b0;
      ag_load_c = 1'b1;
    end else if (busy_q) begin
      if (mismatch_c) begin
        fail_d = 1'b1;
      end
      if (cur_c.two_op && (phase_q == PH_RD)) begin
        phase_d = PH_WR;
      end else if (tc_c) begin
        if (state_q == ST_M5) begin
          // Address holds its last value through DONE
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d        = state_e'(3'(state_q) + 3'd1);
          phase_d        = nxt.first_wr ? PH_WR : PH_RD;
          ag_load_c      = 1'b1;
          ag_load_down_c = nxt.down;
        end
      end else begin
        ag_step_c = 1'b1;
        phase_d   = cur_c.first_wr ? PH_WR : PH_RD;
      end
    end

    ne = elem_info(state_d);
    if (busy_d && (phase_d == PH_WR)) begin
      mem_wr_d    = 1'b1;
      mem_wdata_d = op_inv(ne, phase_d) ? ~BG : BG;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      phase_q     <= PH_RD;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      mem_wr_q    <= mem_wr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign mem_wr    = mem_wr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign fail      = fail_q;

`ifdef BIST_DIAG_EN
  localparam logic [7:0] CNT_MAX = 8'hFF;

  logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
  logic [DATA_W-1:0] fail_data_q, fail_data_d;
  logic [2:0]        fail_elem_q, fail_elem_d;
  logic [7:0]        err_cnt_q, err_cnt_d;

  // First-mismatch capture (gated by the not-yet-set fail flag) and saturating count
  always_comb begin
    fail_addr_d = fail_addr_q;
    fail_data_d = fail_data_q;
    fail_elem_d = fail_elem_q;
    err_cnt_d   = err_cnt_q;
    if (start_ok_c) begin
      fail_addr_d = '0;
      fail_data_d = '0;
      fail_elem_d = '0;
      err_cnt_d   = '0;
    end else if (mismatch_c) begin
      if (!fail_q) begin
        fail_addr_d = mem_addr;
        fail_data_d = mem_rdata;
        fail_elem_d = 3'(state_q);
      end
      if (err_cnt_q != CNT_MAX) begin
        err_cnt_d = err_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_addr_q <= '0;
      fail_data_q <= '0;
      fail_elem_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
      fail_elem_q <= fail_elem_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign fail_addr = fail_addr_q;
  assign fail_data = fail_data_q;
  assign fail_elem = fail_elem_q;
  assign err_cnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_march_bist_ctrl.sv
// Directed bench for march_bist_ctrl: two instances (BG=00 and BG=A5), each on a
// behavioural 256x8 RAM; the BG=00 RAM can inject a stuck bit or invert all reads.
module tb_march_bist_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start1, start2;
  logic [7:0] addr1, wdata1, rdata1, addr2, wdata2, rdata2;
  logic       wr1, busy1, done1, fail1, wr2, busy2, done2, fail2;
`ifdef BIST_DIAG_EN
  logic [7:0] fail_addr1, fail_data1, err_cnt1, fail_addr2, fail_data2, err_cnt2;
  logic [2:0] fail_elem1, fail_elem2;
`endif

  march_bist_ctrl #(.ADDR_W(8), .DATA_W(8), .BG(8'h00)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .mem_addr(addr1), .mem_wdata(wdata1),
    .mem_wr(wr1), .mem_rdata(rdata1), .busy(busy1), .done(done1), .fail(fail1)
`ifdef BIST_DIAG_EN
    , .fail_addr(fail_addr1), .fail_data(fail_data1), .fail_elem(fail_elem1), .err_cnt(err_cnt1)
`endif
  );

  march_bist_ctrl #(.ADDR_W(8), .DATA_W(8), .BG(8'hA5)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .mem_addr(addr2), .mem_wdata(wdata2),
    .mem_wr(wr2), .mem_rdata(rdata2), .busy(busy2), .done(done2), .fail(fail2)
`ifdef BIST_DIAG_EN
    , .fail_addr(fail_addr2), .fail_data(fail_data2), .fail_elem(fail_elem2), .err_cnt(err_cnt2)
`endif
  );

  // RAM models: sync write, async read; fault 1 = addr 3C bit0 stuck-at-1, fault 2 = all reads inverted
  logic [7:0] mem1 [256];
  logic [7:0] mem2 [256];
  int fault = 0;

  always @(posedge clk) begin
    if (wr1) mem1[addr1] <= wdata1;
    if (wr2) mem2[addr2] <= wdata2;
  end
  assign rdata1 = (fault == 1 && addr1 == 8'h3C) ? (mem1[addr1] | 8'h01) :
                  (fault == 2) ? ~mem1[addr1] : mem1[addr1];
  assign rdata2 = mem2[addr2];

  // Bus monitor: selected DUT's bus is compared against an index-based March C- op list
  bit         sel = 1'b0;
  logic       m_busy, m_wr;
  logic [7:0] m_addr, m_wdata, m_bg;
  assign m_busy  = sel ? busy2  : busy1;
  assign m_wr    = sel ? wr2    : wr1;
  assign m_addr  = sel ? addr2  : addr1;
  assign m_wdata = sel ? wdata2 : wdata1;
  assign m_bg    = sel ? 8'hA5  : 8'h00;

  int k = 0, run_len = 0, trace_err = 0, wr_cnt = 0, idle_wr_err = 0;

  always @(negedge clk) begin
    int j, e, r, ea;
    logic ewr;
    logic [7:0] ed;
    if (m_busy) begin
      if (k == 0) begin trace_err = 0; wr_cnt = 0; end
      if (k < 256) begin
        ewr = 1'b1; ea = k; ed = m_bg;
      end else if (k < 2304) begin
        j = k - 256; e = 1 + j / 512; r = j % 512;
        ea = r / 2; ewr = (r % 2) == 1;
        if (e >= 3) ea = 255 - ea;
        ed = (e == 1 || e == 3) ? ~m_bg : m_bg;
      end else begin
        ewr = 1'b0; ea = k - 2304; ed = m_bg;
      end
      if (k >= 2560 || m_wr !== ewr || m_addr !== 8'(ea) || (ewr && m_wdata !== ed))
        trace_err++;
      if (m_wr) wr_cnt++;
      k++;
    end else begin
      if (m_wr) idle_wr_err++;
      if (k != 0) run_len = k;
      k = 0;
    end
  end

  int n_run = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start(input bit which);
    @(negedge clk);
    if (which) start2 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic wait_done(input bit which, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (which ? done2 : done1) begin ok = 1'b1; break; end
    end
    @(negedge clk);
  endtask

  bit ok;

  initial begin
    rst_n = 1'b0; start1 = 1'b0; start2 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_addr", addr1, 8'h00);
    check("rst_wdata", wdata1, 8'h00);
    check("rst_wr", wr1, 1'b0);
    check("rst_busy", busy1, 1'b0);
    check("rst_done", done1, 1'b0);
    check("rst_fail", fail1, 1'b0);
`ifdef BIST_DIAG_EN
    check("rst_diag", {fail_addr1, fail_data1, 5'(fail_elem1), err_cnt1}, 32'h0);
`endif
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", busy1, 1'b0);

    // 1: clean run, BG=00
    pulse_start(1'b0);
    check("t1_lat_busy", busy1, 1'b1);
    check("t1_lat_wr", wr1, 1'b1);
    check("t1_lat_addr", addr1, 8'h00);
    check("t1_lat_wdata", wdata1, 8'h00);
    wait_done(1'b0, ok);
    check("t1_done_seen", ok, 1'b1);
    check("t1_run_len", run_len, 2560);
    check("t1_trace", trace_err, 0);
    check("t1_wr_cnt", wr_cnt, 1280);
    check("t1_busy", busy1, 1'b0);
    check("t1_fail", fail1, 1'b0);
    check("t1_addr_hold", addr1, 8'hFF);

    // 2: stuck-at-1 on addr 3C bit0
    fault = 1;
    pulse_start(1'b0);
    check("t2_done_clr", done1, 1'b0);
    check("t2_busy", busy1, 1'b1);
    wait_done(1'b0, ok);
    check("t2_done_seen", ok, 1'b1);
    check("t2_fail", fail1, 1'b1);
    check("t2_run_len", run_len, 2560);
    check("t2_trace", trace_err, 0);
`ifdef BIST_DIAG_EN
    check("t2_fail_addr", fail_addr1, 8'h3C);
    check("t2_fail_data", fail_data1, 8'h01);
    check("t2_fail_elem", fail_elem1, 3'd1);
    check("t2_err_cnt", err_cnt1, 8'd3);
`endif

    // 3: reset at cycle 1000, then full rerun
    fault = 0;
    pulse_start(1'b0);
    check("t3_fail_clr", fail1, 1'b0);
    repeat (1000) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t3_rst_busy", busy1, 1'b0);
    check("t3_rst_wr", wr1, 1'b0);
    check("t3_rst_addr", addr1, 8'h00);
    check("t3_rst_wdata", wdata1, 8'h00);
    check("t3_rst_done", done1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    pulse_start(1'b0);
    wait_done(1'b0, ok);
    check("t3_done_seen", ok, 1'b1);
    check("t3_run_len", run_len, 2560);
    check("t3_fail", fail1, 1'b0);

    // 4: start re-pulsed mid-run is ignored
    pulse_start(1'b0);
    repeat (500) @(negedge clk);
    pulse_start(1'b0);
    check("t4_still_busy", busy1, 1'b1);
    wait_done(1'b0, ok);
    check("t4_done_seen", ok, 1'b1);
    check("t4_run_len", run_len, 2560);
    check("t4_trace", trace_err, 0);

    // 5: BG=A5 instance
    sel = 1'b1;
    repeat (2) @(negedge clk);
    pulse_start(1'b1);
    check("t5_lat_wr", wr2, 1'b1);
    check("t5_lat_wdata", wdata2, 8'hA5);
    wait_done(1'b1, ok);
    check("t5_done_seen", ok, 1'b1);
    check("t5_run_len", run_len, 2560);
    check("t5_trace", trace_err, 0);
    check("t5_fail", fail2, 1'b0);
    check("t5_mem_10", mem2[8'h10], 8'hA5);
    check("t5_mem_ff", mem2[8'hFF], 8'hA5);
    sel = 1'b0;
    repeat (2) @(negedge clk);

`ifdef BIST_DIAG_EN
    // 6: every read wrong, counter saturates
    fault = 2;
    pulse_start(1'b0);
    wait_done(1'b0, ok);
    check("t6_done_seen", ok, 1'b1);
    check("t6_fail", fail1, 1'b1);
    check("t6_err_cnt", err_cnt1, 8'd255);
    check("t6_fail_addr", fail_addr1, 8'h00);
    check("t6_fail_data", fail_data1, 8'hFF);
    check("t6_fail_elem", fail_elem1, 3'd1);
    fault = 0;
`endif

    check("idle_wr", idle_wr_err, 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
